// File: rtl/alu_arbiter_if.sv
// Request, response and shared-ALU bundle for alu_arbiter.
// slave = arbiter side, master = environment side.
interface alu_arbiter_if #(
  parameter int TAG_W = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [31:0]      req0_src_a;
  logic [31:0]      req0_src_b;
  logic [3:0]       req0_op;
  logic             req0_s;
  logic [TAG_W-1:0] req0_tag;

  logic             req1_valid;
  logic             req1_ready;
  logic [31:0]      req1_src_a;
  logic [31:0]      req1_src_b;
  logic [3:0]       req1_op;
  logic             req1_s;
  logic [TAG_W-1:0] req1_tag;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_port;
  logic [TAG_W-1:0] rsp_tag;
  logic [31:0]      rsp_result;
  logic [3:0]       rsp_status;

  logic [31:0]      alu_src_a;
  logic [31:0]      alu_src_b;
  logic [3:0]       alu_op;
  logic             alu_c_in;
  logic [31:0]      alu_result;
  logic [3:0]       alu_status;

  logic             sr_wr_en;
  logic [3:0]       sr_wr_data;
  logic [3:0]       status_reg;

  modport slave (
    input  req0_valid, req0_src_a, req0_src_b,
    input  req0_op, req0_s, req0_tag,
    output req0_ready,
    input  req1_valid, req1_src_a, req1_src_b,
    input  req1_op, req1_s, req1_tag,
    output req1_ready,
    output rsp_valid, rsp_port, rsp_tag,
    output rsp_result, rsp_status,
    input  rsp_ready,
    output alu_src_a, alu_src_b, alu_op, alu_c_in,
    input  alu_result, alu_status,
    input  sr_wr_en, sr_wr_data,
    output status_reg
  );

  modport master (
    output req0_valid, req0_src_a, req0_src_b,
    output req0_op, req0_s, req0_tag,
    input  req0_ready,
    output req1_valid, req1_src_a, req1_src_b,
    output req1_op, req1_s, req1_tag,
    input  req1_ready,
    input  rsp_valid, rsp_port, rsp_tag,
    input  rsp_result, rsp_status,
    output rsp_ready,
    input  alu_src_a, alu_src_b, alu_op, alu_c_in,
    output alu_result, alu_status,
    output sr_wr_en, sr_wr_data,
    input  status_reg
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port arbiter for the shared EXE ALU; owns status {Z,C,V,N}.
// Define ALU_ARB_PERF_EN to add the perf_grant0/1 and perf_stall counters.
module alu_arbiter #(
  parameter int TAG_W    = 4,
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  alu_arbiter_if.slave bus
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [15:0] perf_grant0,
  output logic [15:0] perf_grant1,
  output logic [15:0] perf_stall
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  state_t           state;
  logic [3:0]       starve;
  logic [3:0]       sr;

  logic [31:0]      lat_a;
  logic [31:0]      lat_b;
  logic [3:0]       lat_op;
  logic             lat_s;
  logic [TAG_W-1:0] lat_tag;
  logic             lat_port;

  logic             rsp_valid;
  logic             rsp_port;
  logic [TAG_W-1:0] rsp_tag;
  logic [31:0]      rsp_result;
  logic [3:0]       rsp_status;

  logic             pick1;
  logic             grant0;
  logic             grant1;

  // Port 1 only wins a contested IDLE cycle once it has starved.
  always_comb begin
    pick1  = bus.req1_valid &
             (~bus.req0_valid | (starve == MAX_W));
    grant1 = (state == IDLE) & pick1;
    grant0 = (state == IDLE) & bus.req0_valid & ~pick1;
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  assign bus.alu_src_a  = lat_a;
  assign bus.alu_src_b  = lat_b;
  assign bus.alu_op     = lat_op;
  assign bus.alu_c_in   = sr[2];

  assign bus.rsp_valid  = rsp_valid;
  assign bus.rsp_port   = rsp_port;
  assign bus.rsp_tag    = rsp_tag;
  assign bus.rsp_result = rsp_result;
  assign bus.rsp_status = rsp_status;
  assign bus.status_reg = sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      starve     <= '0;
      sr         <= '0;
      lat_a      <= '0;
      lat_b      <= '0;
      lat_op     <= '0;
      lat_s      <= 1'b0;
      lat_tag    <= '0;
      lat_port   <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_port   <= 1'b0;
      rsp_tag    <= '0;
      rsp_result <= '0;
      rsp_status <= '0;
    end else begin
      if (bus.sr_wr_en) begin
        sr <= bus.sr_wr_data;
      end
      unique case (state)
        IDLE: begin
          if (grant0 | grant1) begin
            lat_a    <= grant1 ? bus.req1_src_a : bus.req0_src_a;
            lat_b    <= grant1 ? bus.req1_src_b : bus.req0_src_b;
            lat_op   <= grant1 ? bus.req1_op    : bus.req0_op;
            lat_s    <= grant1 ? bus.req1_s     : bus.req0_s;
            lat_tag  <= grant1 ? bus.req1_tag   : bus.req0_tag;
            lat_port <= grant1;
            state    <= EXEC;
            if (grant1) begin
              starve <= '0;
            end else if (bus.req1_valid && starve != MAX_W) begin
              starve <= starve + 4'd1;
            end
          end
        end
        EXEC: begin
          rsp_valid  <= 1'b1;
          rsp_result <= bus.alu_result;
          rsp_status <= bus.alu_status;
          rsp_tag    <= lat_tag;
          rsp_port   <= lat_port;
          // ALU flags override a coincident external write.
          if (lat_s) begin
            sr <= bus.alu_status;
          end
          state <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_PERF_EN
  localparam logic [15:0] SAT = 16'hFFFF;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_grant0 <= '0;
      perf_grant1 <= '0;
      perf_stall  <= '0;
    end else begin
      if (grant0 && perf_grant0 != SAT) begin
        perf_grant0 <= perf_grant0 + 16'd1;
      end
      if (grant1 && perf_grant1 != SAT) begin
        perf_grant1 <= perf_grant1 + 16'd1;
      end
      if (state == RESP && !bus.rsp_ready && perf_stall != SAT) begin
        perf_stall <= perf_stall + 16'd1;
      end
    end
  end
`endif

endmodule
